// File: rtl/mig_ui_responder_if.sv
// UI bus between a traffic generator (master) and the controller-side responder (slave).
interface mig_ui_responder_if #(
    parameter int APP_DATA_WIDTH = 64,
    parameter int APP_ADDR_WIDTH = 33
);
    logic                        app_en;
    logic [2:0]                  app_cmd;
    logic [APP_ADDR_WIDTH-1:0]   app_addr;
    logic                        app_rdy;
    logic                        app_wdf_wren;
    logic                        app_wdf_end;
    logic [APP_DATA_WIDTH-1:0]   app_wdf_data;
    logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask;
    logic                        app_wdf_rdy;
    logic [APP_DATA_WIDTH-1:0]   app_rd_data;
    logic                        app_rd_data_valid;
    logic                        app_rd_data_end;

    modport master (
        output app_en, app_cmd, app_addr,
        output app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_en, app_cmd, app_addr,
        input  app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/mig_ui_responder.sv
// Controller-side responder for the DDR UI bus: clears its RAM after reset, then executes
// queued writes/reads in order and returns read data after a fixed pipeline latency.
module mig_ui_responder #(
    parameter int APP_DATA_WIDTH = 64,
    parameter int APP_ADDR_WIDTH = 33,
    parameter int MEM_LOG_DEPTH  = 10,
    parameter int RD_LATENCY     = 8,
    parameter int CMD_FIFO_LOG   = 3,
    parameter int WDF_FIFO_LOG   = 3,
    parameter int STALL_PERIOD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    mig_ui_responder_if.slave app,
    output logic              init_calib_complete,
    output logic [31:0]       wr_count,
    output logic [31:0]       rd_count,
    output logic              protocol_err,
    output logic [0:0]        dbg_state
);
    localparam int MASK_W    = APP_DATA_WIDTH / 8;
    localparam int CMD_DEPTH = 1 << CMD_FIFO_LOG;
    localparam int WDF_DEPTH = 1 << WDF_FIFO_LOG;
    localparam int MEM_DEPTH = 1 << MEM_LOG_DEPTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Handshakes: a command transfers on a rising edge where app_en && app_rdy, write data where
    // app_wdf_wren && app_wdf_rdy; the ready outputs depend only on registered state, never on
    // the valid inputs. Read data has no backpressure: app_rd_data_valid is a one-cycle pulse.

    logic [0:0]               state_q, state_d;
    logic [MEM_LOG_DEPTH-1:0] clr_idx_q, clr_idx_d;
    logic                     run;

    assign run       = (state_q == ST_RUN);
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == {MEM_LOG_DEPTH{1'b1}}) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Forced command backpressure: one cycle in every STALL_PERIOD while running.
    logic stall;
    generate
        if (STALL_PERIOD > 0) begin : g_stall
            localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIOD - 1);
            logic [SW-1:0] stall_cnt_q, stall_cnt_d;

            always_comb begin
                stall_cnt_d = stall_cnt_q;
                if (run) stall_cnt_d = (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + 1'b1;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) stall_cnt_q <= '0;
                else      stall_cnt_q <= stall_cnt_d;
            end

            assign stall = run && (stall_cnt_q == STALL_LAST);
        end else begin : g_no_stall
            assign stall = 1'b0;
        end
    endgenerate

    // Command FIFO: pointers carry one wrap bit to tell full from empty.
    logic                     cmd_is_rd_mem [CMD_DEPTH];
    logic [MEM_LOG_DEPTH-1:0] cmd_idx_mem   [CMD_DEPTH];
    logic [CMD_FIFO_LOG:0]    cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic                     cmd_full, cmd_empty;
    logic                     cmd_acc, cmd_legal, cmd_push, cmd_pop;

    assign cmd_empty = (cmd_wp_q == cmd_rp_q);
    assign cmd_full  = (cmd_wp_q[CMD_FIFO_LOG] != cmd_rp_q[CMD_FIFO_LOG]) &&
                       (cmd_wp_q[CMD_FIFO_LOG-1:0] == cmd_rp_q[CMD_FIFO_LOG-1:0]);

    assign app.app_rdy = run && !cmd_full && !stall;
    assign cmd_acc     = app.app_en && app.app_rdy;
    assign cmd_legal   = (app.app_cmd == 3'd0) || (app.app_cmd == 3'd1);
    // Illegal codes consume the handshake but never reach the executor.
    assign cmd_push    = cmd_acc && cmd_legal;

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_is_rd_mem[cmd_wp_q[CMD_FIFO_LOG-1:0]] <= app.app_cmd[0];
            cmd_idx_mem[cmd_wp_q[CMD_FIFO_LOG-1:0]]   <= app.app_addr[3 +: MEM_LOG_DEPTH];
        end
    end

    // Write-data FIFO, paired with write commands purely by order.
    logic [APP_DATA_WIDTH-1:0] wdf_data_mem [WDF_DEPTH];
    logic [MASK_W-1:0]         wdf_mask_mem [WDF_DEPTH];
    logic [WDF_FIFO_LOG:0]     wdf_wp_q, wdf_wp_d, wdf_rp_q, wdf_rp_d;
    logic                      wdf_full, wdf_empty, wdf_push, wdf_pop;

    assign wdf_empty = (wdf_wp_q == wdf_rp_q);
    assign wdf_full  = (wdf_wp_q[WDF_FIFO_LOG] != wdf_rp_q[WDF_FIFO_LOG]) &&
                       (wdf_wp_q[WDF_FIFO_LOG-1:0] == wdf_rp_q[WDF_FIFO_LOG-1:0]);

    assign app.app_wdf_rdy = run && !wdf_full;
    assign wdf_push        = app.app_wdf_wren && app.app_wdf_rdy;

    always_ff @(posedge clk) begin
        if (wdf_push) begin
            wdf_data_mem[wdf_wp_q[WDF_FIFO_LOG-1:0]] <= app.app_wdf_data;
            wdf_mask_mem[wdf_wp_q[WDF_FIFO_LOG-1:0]] <= app.app_wdf_mask;
        end
    end

    // Executor: the head write waits for its data, which also holds back every later read.
    logic                      head_is_rd;
    logic [MEM_LOG_DEPTH-1:0]  head_idx;
    logic [APP_DATA_WIDTH-1:0] head_wdata;
    logic [MASK_W-1:0]         head_wmask;
    logic                      rd_pop, wr_pop;

    assign head_is_rd = cmd_is_rd_mem[cmd_rp_q[CMD_FIFO_LOG-1:0]];
    assign head_idx   = cmd_idx_mem[cmd_rp_q[CMD_FIFO_LOG-1:0]];
    assign head_wdata = wdf_data_mem[wdf_rp_q[WDF_FIFO_LOG-1:0]];
    assign head_wmask = wdf_mask_mem[wdf_rp_q[WDF_FIFO_LOG-1:0]];

    assign rd_pop  = !cmd_empty && head_is_rd;
    assign wr_pop  = !cmd_empty && !head_is_rd && !wdf_empty;
    assign cmd_pop = rd_pop || wr_pop;
    assign wdf_pop = wr_pop;

    always_comb begin
        cmd_wp_d = cmd_wp_q;
        cmd_rp_d = cmd_rp_q;
        wdf_wp_d = wdf_wp_q;
        wdf_rp_d = wdf_rp_q;
        if (cmd_push) cmd_wp_d = cmd_wp_q + 1'b1;
        if (cmd_pop)  cmd_rp_d = cmd_rp_q + 1'b1;
        if (wdf_push) wdf_wp_d = wdf_wp_q + 1'b1;
        if (wdf_pop)  wdf_rp_d = wdf_rp_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_wp_q <= '0;
            cmd_rp_q <= '0;
            wdf_wp_q <= '0;
            wdf_rp_q <= '0;
        end else begin
            cmd_wp_q <= cmd_wp_d;
            cmd_rp_q <= cmd_rp_d;
            wdf_wp_q <= wdf_wp_d;
            wdf_rp_q <= wdf_rp_d;
        end
    end

    // Backing RAM; the clear sweep owns the write port until RUN.
    logic [APP_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [APP_DATA_WIDTH-1:0] mem_rd;

    assign mem_rd = mem[head_idx];

    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_pop) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!head_wmask[b]) mem[head_idx][b*8 +: 8] <= head_wdata[b*8 +: 8];
            end
        end
    end

    // Read return pipeline; data stages only advance with a valid beat so the output holds.
    logic [RD_LATENCY-1:0]     rd_vld_q;
    logic [APP_DATA_WIDTH-1:0] rd_data_q [RD_LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) rd_data_q[i] <= '0;
        end else begin
            rd_vld_q[0] <= rd_pop;
            if (rd_pop) rd_data_q[0] <= mem_rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                if (rd_vld_q[i-1]) rd_data_q[i] <= rd_data_q[i-1];
            end
        end
    end

    assign app.app_rd_data       = rd_data_q[RD_LATENCY-1];
    assign app.app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
    assign app.app_rd_data_end   = rd_vld_q[RD_LATENCY-1];

    // Statistics and sticky protocol error.
    logic [31:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic        err_q, err_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q + {31'd0, wr_pop};
        rd_cnt_d = rd_cnt_q + {31'd0, rd_vld_q[RD_LATENCY-1]};
        err_d    = err_q || (cmd_acc && !cmd_legal) || (app.app_wdf_end != app.app_wdf_wren);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign init_calib_complete = run;
    assign wr_count            = wr_cnt_q;
    assign rd_count            = rd_cnt_q;
    assign protocol_err        = err_q;

    // Offset bits and bits above the RAM index do not select storage; addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{app.app_addr[2:0], app.app_addr[APP_ADDR_WIDTH-1:3+MEM_LOG_DEPTH]};
endmodule

// File: tb/tb_mig_ui_responder.sv
// Randomized bench for mig_ui_responder: a RAM model predicts read data, a monitor pops and checks.
module tb_mig_ui_responder;
  localparam int DW = 64;
  localparam int AW = 33;
  localparam int RD_LAT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mig_ui_responder_if #(.APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW)) ui ();

  logic        init_calib_complete;
  logic [31:0] wr_count;
  logic [31:0] rd_count;
  logic        protocol_err;
  logic [0:0]  dbg_state;

  mig_ui_responder #(
    .APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .MEM_LOG_DEPTH(10), .RD_LATENCY(RD_LAT),
    .CMD_FIFO_LOG(3), .WDF_FIFO_LOG(3), .STALL_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .app(ui),
    .init_calib_complete(init_calib_complete),
    .wr_count(wr_count),
    .rd_count(rd_count),
    .protocol_err(protocol_err),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  int acc_cyc = 0;
  int last_beat_cyc = 0;
  int n_beats = 0;
  int n_wr = 0;
  int n_rd = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [1024];
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference memory: word index is address bits [12:3]; a set mask bit keeps the old byte.
  function automatic void apply_write(input logic [32:0] a, input logic [63:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b++) if (!m[b]) model[a[12:3]][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic logic [32:0] rand_addr();
    logic [32:0] a;
    a = '0;
    a[14:13] = 2'($urandom_range(0, 3));
    a[6:3]   = 4'($urandom_range(0, 15));
    a[2:0]   = 3'($urandom_range(0, 7));
    return a;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [2:0] c, input logic [32:0] a);
    int n = 0;
    @(negedge clk);
    ui.app_en = 1'b1; ui.app_cmd = c; ui.app_addr = a;
    while (!ui.app_rdy && n < 500) begin @(negedge clk); n++; end
    if (!ui.app_rdy) begin
      total++; bad++;
      $display("FAIL cmd_timeout: app_rdy stayed 0 for %0d cycles, required 1", n);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    ui.app_en = 1'b0;
  endtask

  task automatic send_data(input logic [63:0] d, input logic [7:0] m);
    int n = 0;
    @(negedge clk);
    ui.app_wdf_wren = 1'b1; ui.app_wdf_end = 1'b1; ui.app_wdf_data = d; ui.app_wdf_mask = m;
    while (!ui.app_wdf_rdy && n < 500) begin @(negedge clk); n++; end
    if (!ui.app_wdf_rdy) begin
      total++; bad++;
      $display("FAIL wdf_timeout: app_wdf_rdy stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0;
  endtask

  task automatic do_read(input logic [32:0] a);
    send_cmd(3'd1, a);
    exp_q.push_back(model[a[12:3]]);
    n_rd++;
  endtask

  // mode 0: command and data together, 1: data first, 2: command first
  task automatic do_write(input logic [32:0] a, input logic [63:0] d, input logic [7:0] m, input int mode);
    apply_write(a, d, m);
    n_wr++;
    if (mode == 0) begin
      fork
        send_cmd(3'd0, a);
        send_data(d, m);
      join
    end else if (mode == 1) begin
      send_data(d, m);
      send_cmd(3'd0, a);
    end else begin
      send_cmd(3'd0, a);
      send_data(d, m);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_init"}, init_calib_complete, 0);
    chk({tag, "_rdy"}, ui.app_rdy, 0);
    chk({tag, "_wdf_rdy"}, ui.app_wdf_rdy, 0);
    chk({tag, "_valid"}, ui.app_rd_data_valid, 0);
    chk({tag, "_rd_data"}, ui.app_rd_data, 0);
    chk({tag, "_wr_count"}, wr_count, 0);
    chk({tag, "_rd_count"}, rd_count, 0);
    chk({tag, "_err"}, protocol_err, 0);
  endtask

  task automatic release_and_calib();
    int pre = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      if (ui.app_rdy || ui.app_wdf_rdy || init_calib_complete) pre++;
      @(negedge clk);
    end
    chk("pre_calib_quiet", pre, 0);
    chk("calib_at_1024", init_calib_complete, 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      last_data = '0;
    end else if (ui.app_rd_data_valid) begin
      last_beat_cyc = cyc;
      last_data = ui.app_rd_data;
      n_beats++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got data %h, required no beat", ui.app_rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rd_data", ui.app_rd_data, mon_exp);
      end
      chk("rd_end", ui.app_rd_data_end, 1);
    end else begin
      chk("rd_end_idle", ui.app_rd_data_end, 0);
      chk("rd_hold", ui.app_rd_data, last_data);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] late;
    logic [7:0] m;
    int highs, lows, last_low, gap_bad, beats0;

    for (int i = 0; i < 1024; i++) model[i] = '0;
    ui.app_en = 0; ui.app_cmd = 0; ui.app_addr = 0;
    ui.app_wdf_wren = 0; ui.app_wdf_end = 0; ui.app_wdf_data = 0; ui.app_wdf_mask = 0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_and_calib();

    // Cleared RAM reads as zero.
    do_read(33'h40);
    wait_drain();

    // Write then read-back with latency measurement.
    do_write(33'h08, 64'h1111_2222_3333_4444, 8'h00, 0);
    send_cmd(3'd1, 33'h08);
    exp_q.push_back(64'h1111_2222_3333_4444);
    n_rd++;
    highs = acc_cyc;
    wait_drain();
    chk("rd_latency", last_beat_cyc - highs, 1 + RD_LAT);
    chk("wr_count_a", wr_count, n_wr);
    chk("rd_count_a", rd_count, n_rd);

    // Late write data: read behind the write must see the new data; queue fills.
    late = {$urandom, $urandom};
    apply_write(33'h10, late, 8'h00);
    n_wr++;
    send_cmd(3'd0, 33'h10);
    do_read(33'h10);
    for (int i = 0; i < 6; i++) do_read(rand_addr());
    highs = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (ui.app_rdy) highs++; end
    chk("rdy_low_when_full", highs, 0);
    send_data(late, 8'h00);
    wait_drain();

    // Byte mask keeps the masked bytes.
    do_write(33'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0);
    do_write(33'h18, 64'h0, 8'h0F, 2);
    send_cmd(3'd1, 33'h18);
    exp_q.push_back(64'h0000_0000_FFFF_FFFF);
    n_rd++;
    wait_drain();

    // Random traffic with mixed data ordering.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_read(rand_addr());
      end else begin
        m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        do_write(rand_addr(), {$urandom, $urandom}, m, int'($urandom_range(0, 2)));
      end
    end
    wait_drain();
    chk("wr_count_b", wr_count, n_wr);
    chk("rd_count_b", rd_count, n_rd);

    // Stall pattern while idle: low exactly one cycle in four.
    lows = 0; last_low = -1; gap_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!ui.app_rdy) begin
        if (last_low >= 0 && i - last_low != 4) gap_bad++;
        last_low = i;
        lows++;
      end
    end
    chk("stall_lows", lows, 10);
    chk("stall_gap", gap_bad, 0);

    // 100 continuous reads, alternating the aliased 0x2000 with 0x0/random.
    do_write(33'h0, {$urandom, $urandom}, 8'h00, 0);
    beats0 = n_beats;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) do_read(33'h2000);
      else if (i % 4 == 1) do_read(33'h0);
      else do_read(rand_addr());
    end
    wait_drain();
    chk("stall_beats", n_beats - beats0, 100);
    chk("rd_count_c", rd_count, n_rd);

    // Illegal command: dropped, sticky error.
    chk("err_clean", protocol_err, 0);
    send_cmd(3'd3, 33'h40);
    @(negedge clk);
    chk("err_bad_cmd", protocol_err, 1);
    repeat (12) @(negedge clk);
    chk("err_sticky", protocol_err, 1);
    chk("wr_count_d", wr_count, n_wr);

    // Reset with reads in flight: nothing may come back.
    for (int i = 0; i < 4; i++) send_cmd(3'd1, rand_addr());
    rst = 1'b0;
    #2;
    check_reset_outputs("midreset");
    for (int i = 0; i < 1024; i++) model[i] = '0;
    n_wr = 0; n_rd = 0;
    repeat (3) @(negedge clk);
    beats0 = n_beats;
    release_and_calib();
    repeat (12) @(negedge clk);
    chk("no_stale_beats", n_beats - beats0, 0);
    chk("err_after_reset", protocol_err, 0);

    // Write burst end mismatch.
    @(negedge clk);
    ui.app_wdf_wren = 1'b1; ui.app_wdf_end = 1'b0; ui.app_wdf_data = '0; ui.app_wdf_mask = '0;
    @(posedge clk); #1;
    ui.app_wdf_wren = 1'b0;
    @(negedge clk);
    chk("err_wdf_end", protocol_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
